// File: rtl/video_line_fetch_pkg.sv
// Shared constants and state encoding for the scanline byte fetcher.
// Display memory bases and geometry of the Apple II 40-column layout.
package video_line_fetch_pkg;

  localparam logic [15:0] TEXT_BASE  = 16'h0400;
  localparam logic [15:0] HIRES_BASE = 16'h2000;
  localparam logic [15:0] ROW_STRIDE = 16'h0028;
  localparam int          COLS       = 40;
  localparam int          LINES      = 192;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

endpackage

// File: rtl/video_line_fetch_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; head entry is visible on dout
// whenever empty is low. Storage is not reset, only pointers and count.
module sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/video_line_fetch.sv
// Scanline byte fetcher: issues interleaved Apple II display reads and streams
// the returned bytes, tagged with their column, to the pixel shifter.
module video_line_fetch #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int COLS       = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_start,
  input  logic [7:0]            line_num,
  input  logic                  mode_hires,
  input  logic                  page2,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic [5:0]            pix_col,
  input  logic                  pix_ready,
  output logic                  busy,
  output logic                  line_done
);
  import video_line_fetch_pkg::*;

  localparam int             CW       = $clog2(FIFO_DEPTH);
  localparam logic [5:0]     LAST_COL = 6'(COLS - 1);
  localparam logic [CW+1:0]  DEPTH_V  = (CW+2)'(FIFO_DEPTH);

  state_t                  state_q, state_d;
  logic [7:0]              line_q;
  logic                    hires_q;
  logic                    page2_q;
  logic [5:0]              issue_col_q;
  logic                    start_ok;
  logic                    issue;
  logic [CW+1:0]           credit_sum;
  logic                    vld_p1;
  logic [5:0]              col_p1;
  logic [CW:0]             fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_WIDTH+5:0]   fifo_dout;
  logic [5:0]              head_col;
  logic                    pop;

  // Text rows use bits [5:3]/[7:6] of line/8; hires adds the 1K scan-row term.
  function automatic logic [ADDR_WIDTH-1:0] line_addr(
    input logic [7:0] ln,
    input logic       hires,
    input logic       pg2,
    input logic [5:0] col
  );
    logic [ADDR_WIDTH-1:0] a;
    if (hires) begin
      a = ADDR_WIDTH'(HIRES_BASE) + (pg2 ? ADDR_WIDTH'(HIRES_BASE) : '0)
        + (ADDR_WIDTH'(ln[2:0]) << 10) + (ADDR_WIDTH'(ln[5:3]) << 7)
        + ADDR_WIDTH'(ln[7:6]) * ADDR_WIDTH'(ROW_STRIDE);
    end else begin
      a = ADDR_WIDTH'(TEXT_BASE) + (pg2 ? ADDR_WIDTH'(TEXT_BASE) : '0)
        + (ADDR_WIDTH'(line_num_row(ln)) << 7)
        + ADDR_WIDTH'(ln[7:6]) * ADDR_WIDTH'(ROW_STRIDE);
    end
    return a + ADDR_WIDTH'(col);
  endfunction

  function automatic logic [2:0] line_num_row(input logic [7:0] ln);
    return ln[5:3];
  endfunction

  assign start_ok   = line_start && (line_num < 8'(LINES));
  assign credit_sum = (CW+2)'(fifo_count) + (CW+2)'(vld_p1);
  assign pop        = pix_ready & ~fifo_empty;
  assign head_col   = fifo_dout[DATA_WIDTH+5:DATA_WIDTH];
  assign issue      = mem_cs & mem_gnt;

  always_comb begin
    state_d   = state_q;
    mem_cs    = 1'b0;
    line_done = 1'b0;
    case (state_q)
      IDLE: if (start_ok) state_d = FETCH;
      FETCH: begin
        // Credit counts the in-flight read so a late response always has a slot.
        mem_cs = (issue_col_q <= LAST_COL) && (credit_sum < DEPTH_V) && !fifo_full;
        if (mem_cs && mem_gnt && issue_col_q == LAST_COL) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && head_col == LAST_COL) begin
          line_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_ok) begin
      state_d   = FETCH;
      line_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_q      <= '0;
      hires_q     <= 1'b0;
      page2_q     <= 1'b0;
      issue_col_q <= '0;
      vld_p1      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        line_q      <= line_num;
        hires_q     <= mode_hires;
        page2_q     <= page2;
        issue_col_q <= '0;
      end else if (issue) begin
        issue_col_q <= issue_col_q + 1'b1;
      end
      // Restart drops whatever read is still in flight.
      vld_p1 <= issue & ~start_ok;
    end
  end

  // p1: read data returns one cycle after the granted request
  always_ff @(posedge clk) begin
    col_p1 <= issue_col_q;
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 6),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (start_ok),
    .push  (vld_p1),
    .din   ({col_p1, mem_rdata}),
    .pop   (pix_ready),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mem_we    = 1'b0;
  assign mem_addr  = mem_cs ? line_addr(line_q, hires_q, page2_q, issue_col_q) : '0;
  assign pix_valid = ~fifo_empty;
  assign pix_data  = pix_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
  assign pix_col   = pix_valid ? head_col : '0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_video_line_fetch.sv
// Directed bench for video_line_fetch: address sequences, stream order,
// backpressure, grant stalls, restart and asynchronous reset.
module tb_video_line_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [7:0]  line_num;
  logic        mode_hires;
  logic        page2;
  logic        mem_cs;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_rdata = 8'h00;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic [5:0]  pix_col;
  logic        pix_ready;
  logic        busy;
  logic        line_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  video_line_fetch #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .COLS       (40)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .line_num   (line_num),
    .mode_hires (mode_hires),
    .page2      (page2),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rdata  (mem_rdata),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_col    (pix_col),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .line_done  (line_done)
  );

  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    logic [15:0] v;
    v = a;
    return v[7:0] ^ v[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [15:0] model_addr(input int ln, input bit hires, input bit pg2, input int col);
    int r;
    int a;
    if (!hires) begin
      r = ln / 8;
      a = 'h400 + int'(pg2) * 'h400 + (r % 8) * 'h80 + (r / 8) * 40 + col;
    end else begin
      a = 'h2000 + int'(pg2) * 'h2000 + (ln % 8) * 'h400 + ((ln / 8) % 8) * 'h80 + (ln / 64) * 40 + col;
    end
    return 16'(a);
  endfunction

  // One-cycle-latency RAM behind the arbiter.
  always @(posedge clk) begin
    if (mem_cs && mem_gnt) mem_rdata <= ram_byte(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_line(input int ln, input bit hires, input bit pg2, input int ready_hold,
                          input bit gnt_toggle, input int abort_at, input int abort_ln,
                          output logic [15:0] first_a, output logic [15:0] last_a);
    int cur_ln = ln;
    int beats = 0;
    int grants = 0;
    int dones = 0;
    int cyc = 0;
    bit pending = 0;
    bit abort_now = 0;
    bit aborted = 0;
    bit prev_stall = 0;
    bit first_seen = 0;
    logic [15:0] prev_addr = '0;
    first_a = '0;
    last_a  = '0;
    @(negedge clk);
    line_start = 1'b1;
    line_num   = 8'(ln);
    mode_hires = hires;
    page2      = pg2;
    pix_ready  = (ready_hold == 0);
    mem_gnt    = 1'b1;
    while (!(dones >= 1 && beats >= 40) && cyc < 600) begin
      @(negedge clk);
      abort_now  = pending;
      pending    = 0;
      line_start = abort_now;
      if (abort_now) line_num = 8'(abort_ln);
      pix_ready = (cyc >= ready_hold);
      mem_gnt   = gnt_toggle ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      #1;
      if (cyc == 0) chk("mem_we", mem_we, 0);
      if (prev_stall) begin
        chk("stall_cs", mem_cs, 1);
        chk("stall_addr", mem_addr, prev_addr);
      end
      prev_stall = mem_cs && !mem_gnt;
      prev_addr  = mem_addr;
      if (mem_cs && mem_gnt) begin
        chk("addr", mem_addr, model_addr(cur_ln, hires, pg2, grants));
        if (!first_seen) first_a = mem_addr;
        first_seen = 1;
        last_a = mem_addr;
        grants++;
        if (abort_at > 0 && !aborted && !abort_now && grants == abort_at) pending = 1;
      end
      if (pix_valid && pix_ready) begin
        chk("pix_col", pix_col, beats);
        chk("pix_data", pix_data, ram_byte(model_addr(cur_ln, hires, pg2, beats)));
        beats++;
      end
      if (line_done) dones++;
      if (ready_hold > 0 && cyc == ready_hold - 1) begin
        chk("bp_grants", grants, 4);
        chk("bp_cs_low", mem_cs, 0);
      end
      if (abort_now) begin
        aborted    = 1;
        cur_ln     = abort_ln;
        beats      = 0;
        grants     = 0;
        first_seen = 0;
      end
      cyc++;
    end
    line_start = 1'b0;
    chk("beats", beats, 40);
    chk("grants", grants, 40);
    chk("dones", dones, 1);
    @(negedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_cs", mem_cs, 0);
    chk("idle_done", line_done, 0);
  endtask

  logic [15:0] fa, la;

  initial begin
    rst_n      = 1'b0;
    line_start = 1'b0;
    line_num   = '0;
    mode_hires = 1'b0;
    page2      = 1'b0;
    mem_gnt    = 1'b0;
    pix_ready  = 1'b0;
    #1;
    chk("rst_cs", mem_cs, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pv", pix_valid, 0);
    chk("rst_pd", pix_data, 0);
    chk("rst_pc", pix_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", line_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Text page 1 line 0
    run_line(0, 0, 0, 0, 0, 0, 0, fa, la);
    chk("t0_first", fa, 16'h0400);
    chk("t0_last", la, 16'h0427);
    run_line(8, 0, 0, 0, 0, 0, 0, fa, la);
    chk("t8_first", fa, 16'h0480);
    run_line(64, 0, 0, 0, 0, 0, 0, fa, la);
    chk("t64_first", fa, 16'h0428);
    run_line(0, 0, 1, 0, 0, 0, 0, fa, la);
    chk("tp2_first", fa, 16'h0800);

    // Hires
    run_line(1, 1, 0, 0, 0, 0, 0, fa, la);
    chk("h1_first", fa, 16'h2400);
    run_line(8, 1, 0, 0, 0, 0, 0, fa, la);
    chk("h8_first", fa, 16'h2080);
    run_line(64, 1, 0, 0, 0, 0, 0, fa, la);
    chk("h64_first", fa, 16'h2028);
    run_line(0, 1, 1, 0, 0, 0, 0, fa, la);
    chk("hp2_first", fa, 16'h4000);
    run_line(191, 1, 0, 0, 0, 0, 0, fa, la);
    chk("h191_last", la, 16'h3FF7);

    // Backpressure, grant stalls, restart at column 10
    run_line(0, 0, 0, 20, 0, 0, 0, fa, la);
    chk("bp_first", fa, 16'h0400);
    run_line(100, 1, 0, 0, 1, 0, 0, fa, la);
    chk("gt_last", la, model_addr(100, 1, 0, 39));
    run_line(0, 0, 0, 0, 0, 10, 8, fa, la);
    chk("ab_first", fa, 16'h0480);
    chk("ab_last", la, 16'h04A7);

    // Out-of-range line is ignored
    @(negedge clk);
    line_start = 1'b1;
    line_num   = 8'd192;
    @(negedge clk);
    line_start = 1'b0;
    #1;
    chk("bad_busy", busy, 0);
    chk("bad_cs", mem_cs, 0);

    // Asynchronous reset in the middle of a fetch
    @(negedge clk);
    line_start = 1'b1;
    line_num   = 8'd0;
    mode_hires = 1'b0;
    page2      = 1'b0;
    pix_ready  = 1'b1;
    mem_gnt    = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_pv", pix_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_cs", mem_cs, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_pv", pix_valid, 0);
    chk("arst_pd", pix_data, 0);
    chk("arst_pc", pix_col, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", line_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_cs", mem_cs, 0);
      chk("post_rst_pv", pix_valid, 0);
    end
    run_line(8, 0, 0, 0, 0, 0, 0, fa, la);
    chk("post_rst_first", fa, 16'h0480);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
